// File: rtl/split_pkg.sv
// rtl/split_pkg.sv - shared types and defaults for the split_* candidate generator
package split_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_CHECK = 3'd2,
        ST_SOL   = 3'd3,
        ST_FAIL  = 3'd4
    } cand_state_t;

    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

endpackage

// File: rtl/split_lfsr.sv
// rtl/split_lfsr.sv - right-shift Galois LFSR with seed load and zero-seed guard
module split_lfsr #(
    parameter int           W    = 32,
    parameter logic [W-1:0] TAPS = W'(32'h8020_0003),
    parameter logic [W-1:0] SEED = W'(32'h0000_0001)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] next
);

    logic [W-1:0] lfsr_q;

    always_comb begin
        next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end

    // An all-zero state would lock the register, so a zero seed becomes 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (load) begin
            lfsr_q <= (seed == '0) ? W'(1) : seed;
        end else if (step) begin
            lfsr_q <= next;
        end
    end

endmodule

// File: rtl/split_cand_gen.sv
// rtl/split_cand_gen.sv - rejection-sampling driver for a combinational split_* checker
module split_cand_gen
    import split_pkg::*;
#(
    parameter int           W         = 32,
    parameter logic [W-1:0] TAPS      = W'(DEFAULT_TAPS),
    parameter logic [W-1:0] SEED      = W'(DEFAULT_SEED),
    parameter int           MAX_TRIES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_load,
    input  logic [W-1:0] seed,
    input  logic         start,
    output logic         busy,
    output logic [W-1:0] cand,
    input  logic         chk_x,
    output logic         sol_valid,
    input  logic         sol_ready,
    output logic [W-1:0] sol_data,
    output logic         fail,
    output logic [15:0]  tries
);

    localparam logic [15:0] MAX_T = 16'(MAX_TRIES);

    cand_state_t  state;
    logic [W-1:0] lfsr_next;
    logic         lfsr_step;
    logic         lfsr_load;

    assign lfsr_step = (state == ST_GEN);
    assign lfsr_load = (state == ST_IDLE) && seed_load;

    split_lfsr #(
        .W    (W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .load  (lfsr_load),
        .seed  (seed),
        .next  (lfsr_next)
    );

    assign busy      = (state != ST_IDLE);
    assign sol_valid = (state == ST_SOL);
    assign fail      = (state == ST_FAIL);

    // cand only changes in GEN, so it is stable through the CHECK cycle
    // where the checker's combinational verdict is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cand     <= '0;
            sol_data <= '0;
            tries    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!seed_load && start) begin
                        tries <= '0;
                        state <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    cand  <= lfsr_next;
                    tries <= tries + 16'd1;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (chk_x) begin
                        sol_data <= cand;
                        state    <= ST_SOL;
                    end else if (tries == MAX_T) begin
                        state <= ST_FAIL;
                    end else begin
                        state <= ST_GEN;
                    end
                end
                ST_SOL: begin
                    if (sol_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
